// File: rtl/friscv_io_axil_master.sv
// AXI4-lite master bridging the core's single load/store request port onto the IO subsystem.
// One transaction in flight; a response timeout reports an error and later drains the stray response.
module friscv_io_axil_master #(
  parameter int ADDRW   = 16,
  parameter int DATAW   = 32,
  parameter int IDW     = 16,
  parameter int XLEN    = 32,
  parameter int AXI_ID  = 'h30,
  parameter int TIMEOUT = 1023
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 srst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wr,
  input  logic [ADDRW-1:0]     req_addr,
  input  logic [XLEN-1:0]      req_wdata,
  input  logic [XLEN/8-1:0]    req_strb,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [XLEN-1:0]      rsp_rdata,
  output logic                 rsp_err,
  output logic                 mst_awvalid,
  input  logic                 mst_awready,
  output logic [ADDRW-1:0]     mst_awaddr,
  output logic [2:0]           mst_awprot,
  output logic [IDW-1:0]       mst_awid,
  output logic                 mst_wvalid,
  input  logic                 mst_wready,
  output logic [DATAW-1:0]     mst_wdata,
  output logic [DATAW/8-1:0]   mst_wstrb,
  input  logic                 mst_bvalid,
  output logic                 mst_bready,
  input  logic [1:0]           mst_bresp,
  input  logic [IDW-1:0]       mst_bid,
  output logic                 mst_arvalid,
  input  logic                 mst_arready,
  output logic [ADDRW-1:0]     mst_araddr,
  output logic [2:0]           mst_arprot,
  output logic [IDW-1:0]       mst_arid,
  input  logic                 mst_rvalid,
  output logic                 mst_rready,
  input  logic [1:0]           mst_rresp,
  input  logic [DATAW-1:0]     mst_rdata,
  input  logic [IDW-1:0]       mst_rid
);

  localparam int NL = DATAW / XLEN;
  localparam int XB = XLEN / 8;
  localparam int SB = DATAW / 8;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]  TMAX = TIMEOUT[CW-1:0];
  localparam logic [IDW-1:0] ID   = AXI_ID[IDW-1:0];

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RESP, DRAIN} state_t;

  state_t           state;
  logic [ADDRW-1:0] addr_q;
  logic [CW-1:0]    cnt;
  logic             drain;
  logic             late_hit;

  function automatic int lane_of(input logic [ADDRW-1:0] a);
    return (int'(a) / XB) % NL;
  endfunction

  function automatic logic [SB-1:0] place_strb(input logic [XB-1:0] s, input int l);
    logic [SB-1:0] r;
    r = '0;
    r[l*XB +: XB] = s;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] pick_lane(input logic [DATAW-1:0] d, input int l);
    return d[l*XLEN +: XLEN];
  endfunction

  // Timeout counter holds at its limit rather than wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == TMAX) ? c : c + 1'b1;
  endfunction

  assign mst_awaddr = addr_q;
  assign mst_araddr = addr_q;
  assign mst_awprot = 3'b000;
  assign mst_arprot = 3'b000;
  assign mst_awid   = ID;
  assign mst_arid   = ID;
  assign late_hit   = drain && ((mst_bvalid && mst_bready) || (mst_rvalid && mst_rready));

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state <= IDLE;       req_ready <= 1'b0;   rsp_valid <= 1'b0;
      rsp_err <= 1'b0;     rsp_rdata <= '0;     addr_q <= '0;
      mst_awvalid <= 1'b0; mst_wvalid <= 1'b0;  mst_wdata <= '0;
      mst_wstrb <= '0;     mst_bready <= 1'b0;  mst_arvalid <= 1'b0;
      mst_rready <= 1'b0;  cnt <= '0;           drain <= 1'b0;
    end else if (srst) begin
      state <= IDLE;       req_ready <= 1'b0;   rsp_valid <= 1'b0;
      rsp_err <= 1'b0;     rsp_rdata <= '0;     addr_q <= '0;
      mst_awvalid <= 1'b0; mst_wvalid <= 1'b0;  mst_wdata <= '0;
      mst_wstrb <= '0;     mst_bready <= 1'b0;  mst_arvalid <= 1'b0;
      mst_rready <= 1'b0;  cnt <= '0;           drain <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            addr_q    <= req_addr;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            if (req_wr) begin
              state       <= WR_REQ;
              mst_awvalid <= 1'b1;
              mst_wvalid  <= 1'b1;
              mst_wdata   <= {NL{req_wdata}};
              mst_wstrb   <= place_strb(req_strb, lane_of(req_addr));
            end else begin
              state       <= RD_REQ;
              mst_arvalid <= 1'b1;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        // AW and W complete independently; move on once both have handshaken.
        WR_REQ: begin
          if (mst_awready) mst_awvalid <= 1'b0;
          if (mst_wready)  mst_wvalid  <= 1'b0;
          if ((!mst_awvalid || mst_awready) && (!mst_wvalid || mst_wready)) begin
            state      <= WR_RESP;
            mst_bready <= 1'b1;
            cnt        <= '0;
          end
        end
        RD_REQ: begin
          if (mst_arready) begin
            mst_arvalid <= 1'b0;
            mst_rready  <= 1'b1;
            cnt         <= '0;
            state       <= RD_RESP;
          end
        end
        WR_RESP: begin
          cnt <= sat_inc(cnt);
          if (mst_bvalid) begin
            mst_bready <= 1'b0;
            rsp_err    <= (mst_bresp != 2'b00) || (mst_bid != ID);
            rsp_rdata  <= '0;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else if (TIMEOUT != 0 && cnt == TMAX) begin
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            drain     <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RD_RESP: begin
          cnt <= sat_inc(cnt);
          if (mst_rvalid) begin
            mst_rready <= 1'b0;
            rsp_err    <= (mst_rresp != 2'b00) || (mst_rid != ID);
            rsp_rdata  <= pick_lane(mst_rdata, lane_of(addr_q));
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else if (TIMEOUT != 0 && cnt == TMAX) begin
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            drain     <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        // A late response may land while the timeout error waits for the core.
        RESP: begin
          if (late_hit) begin
            drain      <= 1'b0;
            mst_bready <= 1'b0;
            mst_rready <= 1'b0;
          end
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (drain && !late_hit) begin
              state <= DRAIN;
            end else begin
              state     <= IDLE;
              req_ready <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (late_hit) begin
            drain      <= 1'b0;
            mst_bready <= 1'b0;
            mst_rready <= 1'b0;
            state      <= IDLE;
            req_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
